branch_predictor: RTL and testbench
===================================

# branch_predictor

Bimodal branch predictor for the RAT CPU fetch/execute path: a table of 2-bit saturating counters indexed by low PC bits. The fetch stage looks up a prediction for each conditional branch. The execute stage later returns the actual outcome, and the block trains the matching counter. An in-order in-flight queue pairs each resolution with the index and direction it was predicted with, and the block flags mispredictions back to the pipeline.

## Interface
- IDX_W, 4: counter-table index width; table holds 2^IDX_W entries.
- PC_W, 10: program counter width.
- Q_DEPTH, 4: in-flight queue depth; power of two, at least 2.
- BP_CLK  in  1  clock; all state updates on the rising edge.
- BP_RST_N  in  1  reset, asynchronous, active-low.
- BP_LOOKUP_VLD  in  1  fetch presents a conditional branch this cycle.
- BP_LOOKUP_PC  in  PC_W  PC of that branch.
- BP_PRED_VLD  out  1  registered; prediction valid this cycle.
- BP_PRED_TAKEN  out  1  registered; predicted direction.
- BP_STALL  out  1  combinational; queue full, lookups are dropped.
- BP_RESOLVE_VLD  in  1  execute resolves the oldest in-flight branch.
- BP_RESOLVE_TAKEN  in  1  actual direction of that branch.
- BP_MISPREDICT  out  1  registered; one-cycle pulse, oldest branch was mispredicted.
- BP_FLUSH  in  1  discard all in-flight entries; counters are not touched.

## Operation
- Index is BP_LOOKUP_PC[IDX_W-1:0]. Aliasing PCs share a counter.
- Each counter encodes 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is counter[1].
- Lookup accepted when BP_LOOKUP_VLD=1, queue not full, and BP_FLUSH=0.
  - Accepted lookup pushes {index, predicted bit} to the queue tail.
  - Accepted lookup registers BP_PRED_VLD=1 and BP_PRED_TAKEN=counter[1].
- Dropped lookups (full or flush) produce BP_PRED_VLD=0 and no push. BP_PRED_TAKEN holds its previous value.
- Resolve with BP_RESOLVE_VLD=1 and queue not empty:
  - pops the head entry.
  - updates that entry's counter: +1 if taken, saturating at 11; -1 if not taken, saturating at 00.
  - registers BP_MISPREDICT = (head predicted bit != BP_RESOLVE_TAKEN).
- Resolve with an empty queue is ignored: no counter change, BP_MISPREDICT=0.
- Read-before-write: a lookup and a resolve to the same index in the same cycle return the pre-update counter value.
- Lookup and resolve in the same cycle:
  - Both act when the queue is neither full nor empty; occupancy is unchanged.
  - When the queue is full, the lookup is dropped even though the resolve pops. BP_STALL is based on current occupancy only.
- Flush and resolve in the same cycle: the resolve (pop, counter update, mispredict) completes, then the queue is cleared to empty.
- Occupancy counter is 0..Q_DEPTH wide. Head and tail pointers wrap modulo Q_DEPTH.
- BP_STALL = (occupancy == Q_DEPTH).

## Timing
- Asynchronous reset while BP_RST_N=0:
  - all counters forced to 10.
  - queue empty, pointers 0.
  - BP_PRED_VLD=0, BP_PRED_TAKEN=0, BP_MISPREDICT=0, BP_STALL=0.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. In-flight entries are lost.
- Lookup sampled at edge N: BP_PRED_VLD/BP_PRED_TAKEN are valid in cycle N to N+1 (1-cycle latency).
- Resolve sampled at edge N: the counter updates at edge N, and BP_MISPREDICT is high for exactly cycle N to N+1. A lookup sampled at edge N+1 or later sees the new counter.
- BP_STALL falls in the cycle after a pop from full. It rises in the cycle after the push that fills the queue.
- Back-to-back lookups at full rate are accepted until the queue is full.

## Test plan
- Reset then lookup PC=0x005 -> next cycle BP_PRED_VLD=1, BP_PRED_TAKEN=1 (counter 10); BP_STALL=0.
- Two lookups at PC=0x005, then resolve not-taken twice:
  - first resolve -> BP_MISPREDICT=1; counter 10->01.
  - second resolve -> BP_MISPREDICT=1; counter 01->00.
  - next lookup of 0x005 -> BP_PRED_TAKEN=0.
- Saturation on index 3 (PCs 0x003 and 0x013 alias):
  - five lookup/taken-resolve pairs -> counter holds at 11, never wraps to 00.
  - one not-taken resolve -> counter 10, still predicts taken.
- Fill the queue with 4 lookups and no resolves -> BP_STALL=1.
  - 5th lookup -> BP_PRED_VLD=0.
  - lookup + resolve in the same cycle while full -> lookup dropped, occupancy 3, BP_STALL=0 next cycle.
- Three lookups in flight, BP_FLUSH=1 -> occupancy 0. A following resolve is ignored: BP_MISPREDICT=0, no counter change.
- Drive counters to 00/11 on several indices, pulse BP_RST_N low between clock edges:
  - outputs go to 0 immediately.
  - after release, every index predicts taken (10) and BP_STALL=0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the bimodal branch predictor.
`timescale 1ns/1ps
interface branch_predictor_if #(
    parameter int PC_W = 10
);
    logic            lookup_vld;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_vld;
    logic            pred_taken;
    logic            stall;
    logic            resolve_vld;
    logic            resolve_taken;
    logic            mispredict;
    logic            flush;

    modport master (
        output lookup_vld, lookup_pc, resolve_vld, resolve_taken, flush,
        input  pred_vld, pred_taken, stall, mispredict
    );

    modport slave (
        input  lookup_vld, lookup_pc, resolve_vld, resolve_taken, flush,
        output pred_vld, pred_taken, stall, mispredict
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by low PC bits,
// with an in-order in-flight queue pairing each resolve with its prediction.
`timescale 1ns/1ps
module branch_predictor #(
    parameter int IDX_W   = 4,
    parameter int PC_W    = 10,
    parameter int Q_DEPTH = 4
) (
    input  logic              bp_clk_i,
    input  logic              bp_rst_n_i,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(Q_DEPTH);
    localparam int OCC_W   = $clog2(Q_DEPTH + 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             predTaken;
    } flight_t;

    logic [1:0]       ctrTable_q [ENTRIES];
    flight_t          fifo_q [Q_DEPTH];
    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic             predVld_q, predVld_d;
    logic             predTaken_q, predTaken_d;
    logic             mispredict_q, mispredict_d;

    logic [PC_W-1:0]  lookupPc;
    logic             unusedPcBits;
    logic [IDX_W-1:0] lookupIdx;
    logic [1:0]       lookupCtr;
    logic [1:0]       headCtr;
    logic [1:0]       headCtrNext;
    flight_t          headEntry;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;

    // Only the low index bits select a counter; aliasing PCs share it.
    assign lookupPc     = bp.lookup_pc;
    assign unusedPcBits = ^lookupPc;
    assign lookupIdx    = lookupPc[IDX_W-1:0];
    assign lookupCtr    = ctrTable_q[lookupIdx];
    assign headEntry    = fifo_q[headPtr_q];
    assign headCtr      = ctrTable_q[headEntry.idx];

    assign full   = (occupancy_q == OCC_W'(Q_DEPTH));
    assign empty  = (occupancy_q == '0);
    assign accept = bp.lookup_vld && !full && !bp.flush;
    assign pop    = bp.resolve_vld && !empty;

    always_comb begin
        headCtrNext = headCtr;
        if (bp.resolve_taken) begin
            if (headCtr != 2'b11) headCtrNext = headCtr + 2'd1;
        end else begin
            if (headCtr != 2'b00) headCtrNext = headCtr - 2'd1;
        end
    end

    always_comb begin
        headPtr_d    = headPtr_q;
        tailPtr_d    = tailPtr_q;
        occupancy_d  = occupancy_q + OCC_W'(accept) - OCC_W'(pop);
        predVld_d    = accept;
        predTaken_d  = accept ? lookupCtr[1] : predTaken_q;
        mispredict_d = pop && (headEntry.predTaken != bp.resolve_taken);

        if (accept) tailPtr_d = tailPtr_q + PTR_W'(1);
        if (pop)    headPtr_d = headPtr_q + PTR_W'(1);

        // A same-cycle resolve still trains and reports before the queue empties.
        if (bp.flush) begin
            headPtr_d   = '0;
            tailPtr_d   = '0;
            occupancy_d = '0;
        end
    end

    always_ff @(posedge bp_clk_i or negedge bp_rst_n_i) begin
        if (!bp_rst_n_i) begin
            headPtr_q    <= '0;
            tailPtr_q    <= '0;
            occupancy_q  <= '0;
            predVld_q    <= 1'b0;
            predTaken_q  <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            headPtr_q    <= headPtr_d;
            tailPtr_q    <= tailPtr_d;
            occupancy_q  <= occupancy_d;
            predVld_q    <= predVld_d;
            predTaken_q  <= predTaken_d;
            mispredict_q <= mispredict_d;
        end
    end

    always_ff @(posedge bp_clk_i or negedge bp_rst_n_i) begin
        if (!bp_rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) ctrTable_q[i] <= 2'b10;
        end else if (pop) begin
            ctrTable_q[headEntry.idx] <= headCtrNext;
        end
    end

    // Queue payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge bp_clk_i) begin
        if (accept) fifo_q[tailPtr_q] <= {lookupIdx, lookupCtr[1]};
    end

    assign bp.pred_vld   = predVld_q;
    assign bp.pred_taken = predTaken_q;
    assign bp.mispredict = mispredict_q;
    assign bp.stall      = full;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural model queues the expected
// outputs per cycle and an independent monitor compares them on the falling edge.
`timescale 1ns/1ps
module tb_branch_predictor;
    localparam int IDX_W   = 4;
    localparam int PC_W    = 10;
    localparam int Q_DEPTH = 4;
    localparam int ENTRIES = 1 << IDX_W;

    typedef struct {
        int idx;
        bit pred;
    } flight_t;

    typedef struct {
        bit vld;
        bit taken;
        bit mis;
        bit stall;
    } expect_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    flight_t modelQ[$];
    expect_t expQ[$];
    int      modelCtr[ENTRIES];
    bit      lastTaken;
    int      checks = 0;
    int      errors = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(PC_W)) bpIf ();

    branch_predictor #(
        .IDX_W  (IDX_W),
        .PC_W   (PC_W),
        .Q_DEPTH(Q_DEPTH)
    ) dut (
        .bp_clk_i  (clk),
        .bp_rst_n_i(rstN),
        .bp        (bpIf)
    );

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < ENTRIES; i++) modelCtr[i] = 2;
        modelQ.delete();
        expQ.delete();
        lastTaken = 1'b0;
    endtask

    // Drive one cycle of inputs and predict what the DUT shows after the next edge.
    task automatic applyStimulus(input bit lv, input int pc, input bit rv, input bit rt, input bit fl);
        flight_t head;
        flight_t entry;
        expect_t e;
        int      idx;
        bit      accept;
        @(negedge clk);
        #1;
        bpIf.lookup_vld    = lv;
        bpIf.lookup_pc     = PC_W'(pc);
        bpIf.resolve_vld   = rv;
        bpIf.resolve_taken = rt;
        bpIf.flush         = fl;

        idx    = pc % ENTRIES;
        accept = lv && (modelQ.size() < Q_DEPTH) && !fl;
        e.vld  = accept;
        e.mis  = 1'b0;
        if (accept) lastTaken = (modelCtr[idx] >= 2);
        e.taken = lastTaken;

        if (rv && modelQ.size() > 0) begin
            head  = modelQ.pop_front();
            e.mis = (head.pred != rt);
            if (rt) modelCtr[head.idx] = (modelCtr[head.idx] < 3) ? modelCtr[head.idx] + 1 : 3;
            else    modelCtr[head.idx] = (modelCtr[head.idx] > 0) ? modelCtr[head.idx] - 1 : 0;
        end
        if (accept) begin
            entry.idx  = idx;
            entry.pred = lastTaken;
            modelQ.push_back(entry);
        end
        if (fl) modelQ.delete();
        e.stall = (modelQ.size() == Q_DEPTH);
        expQ.push_back(e);
    endtask

    // Monitor: compares each registered response against the scoreboard.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (rstN && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pred_vld",   bpIf.pred_vld,   e.vld);
                checkOutput("pred_taken", bpIf.pred_taken, e.taken);
                checkOutput("mispredict", bpIf.mispredict, e.mis);
                checkOutput("stall",      bpIf.stall,      e.stall);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bpIf.lookup_vld    = 1'b0;
        bpIf.lookup_pc     = '0;
        bpIf.resolve_vld   = 1'b0;
        bpIf.resolve_taken = 1'b0;
        bpIf.flush         = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rstN = 1'b1;
        $display("[TB] reset released");

        // Weak-taken start, then two not-taken resolves walk 0x005 down to 00.
        applyStimulus(1, 'h005, 0, 0, 0);
        applyStimulus(1, 'h005, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 'h005, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);

        // Saturation on index 3 through aliasing PCs.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, (i % 2) ? 'h013 : 'h003, 0, 0, 0);
            applyStimulus(0, 0, 1, 1, 0);
        end
        applyStimulus(1, 'h003, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 'h013, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);

        // Fill, overflow, and lookup+resolve while full.
        for (int i = 0; i < 4; i++) applyStimulus(1, 'h020 + i, 0, 0, 0);
        applyStimulus(1, 'h024, 0, 0, 0);
        applyStimulus(1, 'h025, 1, 0, 0);
        applyStimulus(1, 'h026, 1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, i[0], 0);

        // Flush with entries in flight, then an ignored resolve.
        for (int i = 0; i < 3; i++) applyStimulus(1, 'h005, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(1, 'h005, 1, 1, 1);
        applyStimulus(1, 'h005, 0, 0, 0);

        // Push index 3 to 11 and index 5 to 00, then fill so outputs are high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 'h003, 1, 0, 0);
            applyStimulus(1, 'h005, 1, 1, 0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 'h003, 0, 0, 0);

        // Asynchronous reset pulse between clock edges.
        @(negedge clk);
        #2;
        bpIf.lookup_vld  = 1'b0;
        bpIf.resolve_vld = 1'b0;
        bpIf.flush       = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_pred_vld",   bpIf.pred_vld,   1'b0);
        checkOutput("async_rst_pred_taken", bpIf.pred_taken, 1'b0);
        checkOutput("async_rst_mispredict", bpIf.mispredict, 1'b0);
        checkOutput("async_rst_stall",      bpIf.stall,      1'b0);
        resetModel();
        #1 rstN = 1'b1;

        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus(1, i, 0, 0, 0);
            applyStimulus(0, 0, 1, 1, 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 1023),
                          $urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 99) < 4);
        end

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", expQ.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
